draw_scheduler: RTL and testbench

- Per-frame sequencer that shares the single line-drawer / frame-buffer write path between a screen clear and NUM_OBJ sprite requesters (bird, pipes).
- On each frame tick it snapshots all object coordinates, then issues one clear.
- It then issues one line-draw per valid object in fixed index order, using start/done handshakes.
- Sits between the game-logic position registers and the line drawer, replacing free-running coordinate muxing.

---
 rtl/draw_pkg.sv | 28 ++
 rtl/obj_snapshot.sv | 59 +++++
 rtl/draw_scheduler.sv | 171 +++++++++++++++++
 tb/tb_draw_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Purpose: shared types and constants for the per-frame draw sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package draw_pkg;

    // Default coordinate width; matches the frame-buffer address width.
    localparam int COORD_W = 11;

    // The bird always occupies slot 0 so it is drawn first, under the pipes.
    localparam int BIRD_IDX = 0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        CLEAR_WAIT = 3'd2,
        SCAN       = 3'd3,
        WAIT       = 3'd4,
        DONE       = 3'd5
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
    } coord_t;

endpackage

// File: rtl/obj_snapshot.sv
// Purpose: frame-stable copy of every requester's valid bit and endpoints, read by index.
// Latency: load takes effect on the next clock; read is combinational from the registers.
// Backpressure: none; loads whenever load_i is high.
//
// Ports: clock/reset (sync, active-high); load_i captures valid_i and the packed
// x0/y0/x1/y1 buses (object k at [k*N +: N]); rd_idx_i selects the object presented
// on rd_valid_o and rd_x0_o..rd_y1_o.
module obj_snapshot
    import draw_pkg::*;
#(
    parameter int N       = COORD_W,
    parameter int NUM_OBJ = 4,
    parameter int IDX_W   = $clog2(NUM_OBJ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [NUM_OBJ-1:0]   valid_i,
    input  logic [NUM_OBJ*N-1:0] x0_i,
    input  logic [NUM_OBJ*N-1:0] y0_i,
    input  logic [NUM_OBJ*N-1:0] x1_i,
    input  logic [NUM_OBJ*N-1:0] y1_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic                 rd_valid_o,
    output logic [N-1:0]         rd_x0_o,
    output logic [N-1:0]         rd_y0_o,
    output logic [N-1:0]         rd_x1_o,
    output logic [N-1:0]         rd_y1_o
);

    logic [NUM_OBJ-1:0]   valid_q;
    logic [NUM_OBJ*N-1:0] x0_q;
    logic [NUM_OBJ*N-1:0] y0_q;
    logic [NUM_OBJ*N-1:0] x1_q;
    logic [NUM_OBJ*N-1:0] y1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            x0_q    <= x0_i;
            y0_q    <= y0_i;
            x1_q    <= x1_i;
            y1_q    <= y1_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_x0_o    = x0_q[rd_idx_i*N +: N];
    assign rd_y0_o    = y0_q[rd_idx_i*N +: N];
    assign rd_x1_o    = x1_q[rd_idx_i*N +: N];
    assign rd_y1_o    = y1_q[rd_idx_i*N +: N];

endmodule

// File: rtl/draw_scheduler.sv
// Purpose: per-frame sequencer sharing the line drawer between one clear and NUM_OBJ sprites.
// Latency: clear_start one cycle after frame_start; each line_start one cycle after its SCAN slot.
// Backpressure: holds in SCAN while line_ready is low; waits on clear_done / line_done handshakes.
//
// Ports: frame_start begins a frame (snapshot of obj_valid/obj_* taken then); clear_start,
// line_start and frame_done are registered one-cycle pulses; x0..y1/obj_idx are registered
// and hold between draws; busy is high outside IDLE; overrun is sticky until reset.
// NUM_OBJ must be at least 2 so that IDX_W is non-zero.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int N       = COORD_W,
    parameter int NUM_OBJ = 4,
    parameter int IDX_W   = $clog2(NUM_OBJ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [NUM_OBJ-1:0]   obj_valid,
    input  logic [NUM_OBJ*N-1:0] obj_x0,
    input  logic [NUM_OBJ*N-1:0] obj_y0,
    input  logic [NUM_OBJ*N-1:0] obj_x1,
    input  logic [NUM_OBJ*N-1:0] obj_y1,
    input  logic                 clear_done,
    input  logic                 line_ready,
    input  logic                 line_done,
    output logic                 clear_start,
    output logic                 line_start,
    output logic [N-1:0]         x0,
    output logic [N-1:0]         y0,
    output logic [N-1:0]         x1,
    output logic [N-1:0]         y1,
    output logic [IDX_W-1:0]     obj_idx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             clear_start_q;
    logic             line_start_q;
    logic             frame_done_q;
    logic             overrun_q;
    logic [IDX_W-1:0] obj_idx_q;
    logic [N-1:0]     x0_q, y0_q, x1_q, y1_q;

    logic             snap_load;
    logic             snap_vld;
    logic [N-1:0]     snap_x0, snap_y0, snap_x1, snap_y1;
    logic             at_last;

    // Only an idle scheduler accepts a new frame; a frame_start seen while busy
    // must not disturb the coordinates of the frame in flight.
    assign snap_load = frame_start && (state_q == IDLE);
    assign at_last   = (idx_q == LAST_IDX);

    obj_snapshot #(
        .N       (N),
        .NUM_OBJ (NUM_OBJ),
        .IDX_W   (IDX_W)
    ) u_snap (
        .clock      (clock),
        .reset      (reset),
        .load_i     (snap_load),
        .valid_i    (obj_valid),
        .x0_i       (obj_x0),
        .y0_i       (obj_y0),
        .x1_i       (obj_x1),
        .y1_i       (obj_y1),
        .rd_idx_i   (idx_q),
        .rd_valid_o (snap_vld),
        .rd_x0_o    (snap_x0),
        .rd_y0_o    (snap_y0),
        .rd_x1_o    (snap_x1),
        .rd_y1_o    (snap_y1)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            clear_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
            obj_idx_q     <= '0;
            x0_q          <= '0;
            y0_q          <= '0;
            x1_q          <= '0;
            y1_q          <= '0;
        end else begin
            // Pulses default low; each is raised for exactly one state transition.
            clear_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_done_q  <= 1'b0;

            // DONE counts as busy, so a frame_start coincident with frame_done overruns.
            if (frame_start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        idx_q         <= IDX_W'(BIRD_IDX);
                        clear_start_q <= 1'b1;
                        state_q       <= CLEAR;
                    end
                end
                CLEAR: begin
                    state_q <= CLEAR_WAIT;
                end
                CLEAR_WAIT: begin
                    if (clear_done) begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!snap_vld) begin
                        if (at_last) begin
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else if (line_ready) begin
                        x0_q         <= snap_x0;
                        y0_q         <= snap_y0;
                        x1_q         <= snap_x1;
                        y1_q         <= snap_y1;
                        obj_idx_q    <= idx_q;
                        line_start_q <= 1'b1;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (line_done) begin
                        if (at_last) begin
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign clear_start = clear_start_q;
    assign line_start  = line_start_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != IDLE);
    assign obj_idx     = obj_idx_q;
    assign x0          = x0_q;
    assign y0          = y0_q;
    assign x1          = x1_q;
    assign y1          = y1_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Purpose: scoreboard bench for draw_scheduler with directed frames and modelled clear/line engines.
// Latency: engines answer 3 cycles after each start pulse.
// Backpressure: line_ready is driven directly by the stimulus.
module tb_draw_scheduler;

    localparam int N       = 11;
    localparam int NUM_OBJ = 4;
    localparam int IDX_W   = 2;

    localparam int EV_CLEAR = 0;
    localparam int EV_LINE  = 1;
    localparam int EV_DONE  = 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 frame_start;
    logic [NUM_OBJ-1:0]   obj_valid;
    logic [NUM_OBJ*N-1:0] obj_x0, obj_y0, obj_x1, obj_y1;
    logic                 clear_done;
    logic                 line_ready;
    logic                 line_done;
    logic                 clear_start, line_start, busy, frame_done, overrun;
    logic [N-1:0]         x0, y0, x1, y1;
    logic [IDX_W-1:0]     obj_idx;

    logic cd_resp = 1'b0;
    logic ld_resp = 1'b0;
    logic ld_stray = 1'b0;

    assign clear_done = cd_resp;
    assign line_done  = ld_resp | ld_stray;

    always #5 clock = ~clock;

    draw_scheduler #(.N(N), .NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .obj_valid   (obj_valid),
        .obj_x0      (obj_x0),
        .obj_y0      (obj_y0),
        .obj_x1      (obj_x1),
        .obj_y1      (obj_y1),
        .clear_done  (clear_done),
        .line_ready  (line_ready),
        .line_done   (line_done),
        .clear_start (clear_start),
        .line_start  (line_start),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .obj_idx     (obj_idx),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    typedef struct {
        int kind;
        int idx;
        int x0, y0, x1, y1;
    } exp_t;

    exp_t exp_q[$];
    int   m_x0[NUM_OBJ], m_y0[NUM_OBJ], m_x1[NUM_OBJ], m_y1[NUM_OBJ];
    int   tests = 0;
    int   fails = 0;
    int   clear_cnt = 0;
    int   line_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives the DUT bus and the reference model together.
    task automatic set_obj(input int k, input int ax0, input int ay0, input int ax1, input int ay1);
        obj_x0[k*N +: N] = N'(ax0);
        obj_y0[k*N +: N] = N'(ay0);
        obj_x1[k*N +: N] = N'(ax1);
        obj_y1[k*N +: N] = N'(ay1);
        m_x0[k] = ax0; m_y0[k] = ay0; m_x1[k] = ax1; m_y1[k] = ay1;
    endtask

    // Expected event stream for one frame: clear, a line per valid slot in index order, done.
    task automatic push_frame(input logic [NUM_OBJ-1:0] vld);
        exp_t e;
        e = '{kind: EV_CLEAR, idx: 0, x0: 0, y0: 0, x1: 0, y1: 0};
        exp_q.push_back(e);
        for (int k = 0; k < NUM_OBJ; k++) begin
            if (vld[k]) begin
                e = '{kind: EV_LINE, idx: k, x0: m_x0[k], y0: m_y0[k], x1: m_x1[k], y1: m_y1[k]};
                exp_q.push_back(e);
            end
        end
        e = '{kind: EV_DONE, idx: 0, x0: 0, y0: 0, x1: 0, y1: 0};
        exp_q.push_back(e);
    endtask

    task automatic start_frame();
        @(posedge clock); #1 frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 400 && busy; c++) @(negedge clock);
        check({name, "_idle"}, int'(busy), 0);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_clear(input int base);
        for (int c = 0; c < 50 && clear_cnt == base; c++) @(negedge clock);
        check("clear_seen", clear_cnt, base + 1);
    endtask

    task automatic sb_take(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got event kind %0d expected none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            if (kind == EV_LINE && e.kind == EV_LINE) begin
                check("line_idx", int'(obj_idx), e.idx);
                check("line_x0", int'(x0), e.x0);
                check("line_y0", int'(y0), e.y0);
                check("line_x1", int'(x1), e.x1);
                check("line_y1", int'(y1), e.y1);
            end
        end
    endtask

    // Monitor: every output pulse is matched against the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clock);
            if (reset !== 1'b1) begin
                if (clear_start) begin clear_cnt++; sb_take(EV_CLEAR); end
                if (line_start)  begin line_cnt++;  sb_take(EV_LINE);  end
                if (frame_done)  sb_take(EV_DONE);
            end
        end
    end

    // Clear engine model.
    initial begin
        forever begin
            @(negedge clock);
            if (clear_start) begin
                repeat (3) @(negedge clock);
                cd_resp = 1'b1;
                @(negedge clock);
                cd_resp = 1'b0;
            end
        end
    end

    // Line drawer model.
    initial begin
        forever begin
            @(negedge clock);
            if (line_start) begin
                repeat (3) @(negedge clock);
                ld_resp = 1'b1;
                @(negedge clock);
                ld_resp = 1'b0;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clock);
        $display("FAIL watchdog: simulation did not finish, fails so far %0d", fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset       = 1'b1;
        frame_start = 1'b0;
        obj_valid   = '0;
        obj_x0 = '0; obj_y0 = '0; obj_x1 = '0; obj_y1 = '0;
        line_ready  = 1'b1;
        for (int k = 0; k < NUM_OBJ; k++) set_obj(k, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_line_start", int'(line_start), 0);
        check("rst_clear_start", int'(clear_start), 0);
        check("rst_frame_done", int'(frame_done), 0);

        // All valid, endpoints (k,k,k+10,k+10).
        for (int k = 0; k < NUM_OBJ; k++) set_obj(k, k, k, k + 10, k + 10);
        obj_valid = 4'b1111;
        push_frame(4'b1111);
        start_frame();
        wait_idle("all_valid");
        check("hold_obj_idx", int'(obj_idx), 3);
        check("hold_x1", int'(x1), 13);
        check("no_overrun", int'(overrun), 0);

        // Sparse mask: only slots 1 and 3 drawn.
        for (int k = 0; k < NUM_OBJ; k++) set_obj(k, 100 + k, 200 + k, 300 + k, 400 + k);
        obj_valid = 4'b1010;
        base = line_cnt;
        push_frame(4'b1010);
        start_frame();
        wait_idle("sparse");
        check("sparse_lines", line_cnt - base, 2);

        // All invalid: clear then done, no lines.
        obj_valid = 4'b0000;
        base = line_cnt;
        push_frame(4'b0000);
        start_frame();
        wait_idle("none_valid");
        check("none_lines", line_cnt - base, 0);

        // Drawer backpressure on slot 0.
        set_obj(0, 7, 8, 9, 10);
        obj_valid  = 4'b0001;
        line_ready = 1'b0;
        base = line_cnt;
        push_frame(4'b0001);
        start_frame();
        wait_clear(clear_cnt - 1 + 1 - 1);
        repeat (10) @(negedge clock);
        check("bp_held", line_cnt, base);
        @(posedge clock); #1 line_ready = 1'b1;
        @(negedge clock);
        check("bp_no_early", int'(line_start), 0);
        @(negedge clock);
        check("bp_fire", int'(line_start), 1);
        wait_idle("backpressure");

        // Stray line_done in CLEAR_WAIT and in SCAN must not skip anything.
        for (int k = 0; k < NUM_OBJ; k++) set_obj(k, 3 * k + 1, 3 * k + 2, 3 * k + 500, 3 * k + 600);
        obj_valid  = 4'b1111;
        line_ready = 1'b0;
        base = clear_cnt;
        push_frame(4'b1111);
        start_frame();
        wait_clear(base);
        @(posedge clock); #1 ld_stray = 1'b1;
        @(posedge clock); #1 ld_stray = 1'b0;
        repeat (8) @(negedge clock);
        @(posedge clock); #1 ld_stray = 1'b1;
        @(posedge clock); #1 ld_stray = 1'b0;
        repeat (2) @(negedge clock);
        base = line_cnt;
        line_ready = 1'b1;
        wait_idle("stray");
        check("stray_lines", line_cnt - base, 4);

        // Snapshot isolation and sticky overrun.
        set_obj(0, 5, 1, 2, 3);
        obj_valid = 4'b0001;
        base = clear_cnt;
        push_frame(4'b0001);
        start_frame();
        wait_clear(base);
        @(posedge clock); #1;
        set_obj(0, 99, 1, 2, 3);
        frame_start = 1'b1;
        @(posedge clock); #1 frame_start = 1'b0;
        @(negedge clock);
        check("overrun_set", int'(overrun), 1);
        wait_idle("snapshot");
        check("overrun_sticky1", int'(overrun), 1);
        push_frame(4'b0001);
        start_frame();
        wait_idle("after_overrun");
        check("overrun_sticky2", int'(overrun), 1);
        check("new_snapshot_x0", int'(x0), 99);

        // Reset while waiting on slot 2's line.
        for (int k = 0; k < NUM_OBJ; k++) set_obj(k, k + 20, k + 30, k + 40, k + 50);
        obj_valid = 4'b1111;
        base = line_cnt;
        push_frame(4'b1111);
        start_frame();
        for (int c = 0; c < 200 && line_cnt < base + 3; c++) @(negedge clock);
        check("mid_lines", line_cnt - base, 3);
        reset = 1'b1;
        @(negedge clock);
        check("mr_line_start", int'(line_start), 0);
        check("mr_clear_start", int'(clear_start), 0);
        check("mr_frame_done", int'(frame_done), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_overrun", int'(overrun), 0);
        check("mr_obj_idx", int'(obj_idx), 0);
        check("mr_x0", int'(x0), 0);
        check("mr_y0", int'(y0), 0);
        check("mr_x1", int'(x1), 0);
        check("mr_y1", int'(y1), 0);
        exp_q.delete();
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check("post_reset_idle", int'(busy), 0);
        push_frame(4'b1111);
        start_frame();
        wait_idle("restart");
        check("restart_overrun", int'(overrun), 0);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
